// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC geometry, generator polynomial and checker states.
// Optional error counter width is present only with CRC_ERRCNT_EN.
package crc_pkg;

    localparam int CRC_N = 16;
    localparam int CRC_R = 7;
    localparam logic [CRC_R-1:0] CRC_DIV = 7'b1111011;

`ifdef CRC_ERRCNT_EN
    localparam int CRC_CNT_W = 8;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } crc_state_e;

endpackage

// File: rtl/crc_check_if.sv
// crc_check_if: codeword in / result out valid-ready bundle.
// err_count exists only when CRC_ERRCNT_EN is defined.
interface crc_check_if
    import crc_pkg::*;
#(
    parameter int N = CRC_N,
    parameter int R = CRC_R
`ifdef CRC_ERRCNT_EN
    , parameter int CNT_W = CRC_CNT_W
`endif
);

    logic           in_valid;
    logic           in_ready;
    logic [N+R-2:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_msg;
    logic [R-2:0]   out_syn;
    logic           crc_err;
`ifdef CRC_ERRCNT_EN
    logic [CNT_W-1:0] err_count;
`endif

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_msg, out_syn, crc_err
`ifdef CRC_ERRCNT_EN
        , input err_count
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_msg, out_syn, crc_err
`ifdef CRC_ERRCNT_EN
        , output err_count
`endif
    );

endinterface

// File: rtl/crc_div_step.sv
// crc_div_step: one bit of MSB-first polynomial division.
// Shifts bit_i into the remainder and reduces by DIV when the top bit is set.
module crc_div_step
    import crc_pkg::*;
#(
    parameter int R = CRC_R,
    parameter logic [R-1:0] DIV = CRC_DIV
) (
    input  logic [R-2:0] rem_i,
    input  logic         bit_i,
    output logic [R-2:0] rem_o
);

    logic [R-1:0] t;

    // Append the new bit, subtract the divisor if degree reaches R-1
    always_comb begin
        t = {rem_i, bit_i};
        if (t[R-1]) begin
            t = t ^ DIV;
        end
        rem_o = t[R-2:0];
    end

endmodule

// File: rtl/crc_check.sv
// crc_check: bit-serial receive CRC checker, returns message, syndrome, error.
// Define CRC_ERRCNT_EN to add a saturating count of errored results.
module crc_check
    import crc_pkg::*;
#(
    parameter int N = CRC_N,
    parameter int R = CRC_R,
    parameter logic [R-1:0] DIV = CRC_DIV
`ifdef CRC_ERRCNT_EN
    , parameter int CNT_W = CRC_CNT_W
`endif
) (
    input logic        clk,
    input logic        rst,
    crc_check_if.slave bus
);

    localparam int W  = N + R - 1;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    crc_state_e    state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [N-1:0]  msg_q, msg_d;
    logic [R-2:0]  rem_q, rem_d;
    logic [R-2:0]  rem_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  out_msg_q, out_msg_d;
    logic [R-2:0]  out_syn_q, out_syn_d;
    logic          crc_err_q, crc_err_d;

    crc_div_step #(
        .R   (R),
        .DIV (DIV)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (sr_q[W-1]),
        .rem_o (rem_nxt)
    );

    // Next-state: accept in IDLE, one division step per clk, hold in DONE
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        msg_d     = msg_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        out_msg_d = out_msg_q;
        out_syn_d = out_syn_q;
        crc_err_d = crc_err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_d    = bus.in_data;
                    msg_d   = bus.in_data[W-1:R-1];
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                rem_d = rem_nxt;
                sr_d  = sr_q << 1;
                if (cnt_q == LAST) begin
                    state_d   = DONE;
                    out_syn_d = rem_nxt;
                    crc_err_d = |rem_nxt;
                    out_msg_d = msg_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            msg_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            out_msg_q <= '0;
            out_syn_q <= '0;
            crc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            msg_q     <= msg_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            out_msg_q <= out_msg_d;
            out_syn_q <= out_syn_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_msg   = out_msg_q;
    assign bus.out_syn   = out_syn_q;
    assign bus.crc_err   = crc_err_q;

`ifdef CRC_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Count errored results as they are consumed, sticking at all-ones
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == DONE) && bus.out_ready && crc_err_q
            && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_check.sv
// tb_crc_check: directed vectors for crc_check, hand-computed expectations.
// With CRC_ERRCNT_EN the counter is built 2 bits wide to exercise saturation.
module tb_crc_check;

    localparam int N = 16;
    localparam int R = 7;
    localparam int W = N + R - 1;
`ifdef CRC_ERRCNT_EN
    localparam int CNT_W = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    crc_check_if #(
        .N (N),
        .R (R)
`ifdef CRC_ERRCNT_EN
        , .CNT_W (CNT_W)
`endif
    ) bus ();

    crc_check #(
        .N   (N),
        .R   (R),
        .DIV (7'b1111011)
`ifdef CRC_ERRCNT_EN
        , .CNT_W (CNT_W)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [W-1:0] cw);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = cw;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd22);
    endtask

    task automatic run(input string tag, input logic [W-1:0] cw,
                       input logic [5:0] syn, input logic err,
                       input logic [15:0] msg);
        send(tag, cw);
        wait_done(tag);
        chk({tag, "_syn"}, 32'(bus.out_syn), 32'(syn));
        chk({tag, "_err"}, 32'(bus.crc_err), 32'(err));
        chk({tag, "_msg"}, 32'(bus.out_msg), 32'(msg));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_rel"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    initial begin
        logic seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_msg", 32'(bus.out_msg), 32'd0);
        chk("rst_out_syn", 32'(bus.out_syn), 32'd0);
        chk("rst_crc_err", 32'(bus.crc_err), 32'd0);
`ifdef CRC_ERRCNT_EN
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
`endif

        run("zero", 22'h000000, 6'h00, 1'b0, 16'h0000);
        run("div",  22'h00007B, 6'h00, 1'b0, 16'h0001);
        run("one",  22'h000001, 6'h01, 1'b1, 16'h0000);
        run("x6",   22'h000040, 6'h3B, 1'b1, 16'h0001);
        run("enc",  22'h394F7C, 6'h00, 1'b0, 16'hE53D);
        run("flip", 22'h394B7C, 6'h13, 1'b1, 16'hE52D);

        send("hold", 22'h000040);
        wait_done("hold");
        repeat (5) begin
            tick();
            chk("hold", 32'({bus.out_valid, bus.in_ready, bus.crc_err,
                             bus.out_syn, bus.out_msg}),
                32'({1'b1, 1'b0, 1'b1, 6'h3B, 16'h0001}));
        end

        bus.in_valid  = 1'b1;
        bus.in_data   = 22'h000001;
        bus.out_ready = 1'b1;
        tick();
        chk("b2b_idle", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        bus.out_ready = 1'b0;
        tick();
        chk("b2b_acc", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        wait_done("b2b");
        chk("b2b_syn", 32'(bus.out_syn), 32'h01);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        send("rsh", 22'h000040);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsh_state", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        chk("rsh_syn", 32'(bus.out_syn), 32'd0);
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rsh_nores", 32'(seen), 32'd0);

        send("rdn", 22'h000001);
        wait_done("rdn");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rdn_state", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        chk("rdn_err", 32'(bus.crc_err), 32'd0);

`ifdef CRC_ERRCNT_EN
        chk("ec_start", 32'(bus.err_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            run("ec", 22'h000001, 6'h01, 1'b1, 16'h0000);
            chk("err_count", 32'(bus.err_count), (i < 2) ? 32'(i + 1) : 32'd3);
        end
        run("ec_ok", 22'h000000, 6'h00, 1'b0, 16'h0000);
        chk("err_count_ok", 32'(bus.err_count), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
